// File: rtl/systolic_mac_array_pkg.sv
// systolic_mac_array_pkg
//   Shared types and sizing helpers for the output-stationary systolic
//   matrix-multiply array.
//   - state_e     : top-level sequencing state (LOAD / PROP / DRAIN)
//   - cnt_width() : width of a counter that indexes 0..n-1 (at least 1 bit),
//                   i.e. $clog2(W+H) for the loader and propagation counters
//   - idx_width() : width of a counter that must also hold the value n,
//                   i.e. $clog2(H*W)+1 for the drain index
package systolic_mac_array_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PROP  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe
//   One multiply-accumulate processing element of the systolic array.
//   The A operand travels left-to-right and the B operand travels top-down,
//   each through one register stage with its own valid bit. When both
//   incoming operands are valid in the same cycle the PE adds a*b (truncated
//   to width_p) into its accumulator, which wraps modulo 2^width_p.
// Ports
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : global enable, low freezes every register
//   clear_i        : zero the accumulator (takes priority over accumulate)
//   a_i / a_v_i    : A operand and valid from the left neighbour / injector
//   b_i / b_v_i    : B operand and valid from the upper neighbour / injector
//   a_o / a_v_o    : registered A pass-through to the right
//   b_o / b_v_o    : registered B pass-through downward
//   acc_o          : current accumulator value
module systolic_mac_pe
  import systolic_mac_array_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] a_i,
  input  logic               a_v_i,
  input  logic [width_p-1:0] b_i,
  input  logic               b_v_i,
  output logic [width_p-1:0] a_o,
  output logic               a_v_o,
  output logic [width_p-1:0] b_o,
  output logic               b_v_o,
  output logic [width_p-1:0] acc_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_o   <= '0;
      a_v_o <= 1'b0;
      b_o   <= '0;
      b_v_o <= 1'b0;
      acc_o <= '0;
    end else if (en_i) begin
      a_o   <= a_i;
      a_v_o <= a_v_i;
      b_o   <= b_i;
      b_v_o <= b_v_i;
      if (clear_i) begin
        acc_o <= '0;
      end else if (a_v_i && b_v_i) begin
        // Expression is width_p wide, so the product truncates and the
        // sum wraps naturally.
        acc_o <= acc_o + a_i * b_i;
      end
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// systolic_mac_array
//   Output-stationary array_height_p x array_width_p systolic matrix
//   multiplier. Operands arrive serially, one k-slice at a time: first the
//   array_width_p B-row words (column 0 first), then the array_height_p
//   A-column words (row 0 first). A complete slice is injected into the array
//   with skew so that PE(r,c) sees a_r and b_c together r+c cycles after
//   injection starts. A flush request drains C = A*B row-major through a
//   registered output and then clears the accumulators.
//
//   Handshakes: an input word is consumed on a rising edge where
//   valid_i & ready_o are both high (ready_o already includes en_i and
//   reset_i). valid_o marks data_o as a result element; results are
//   pushed out unconditionally, yumi_i is reserved and has no effect.
// Ports
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : global enable, low holds all state and blocks handshakes
//   flush_i        : request to drain the result matrix
//   ready_o        : loader can accept a word
//   valid_i, data_i: operand word input
//   valid_o, data_o: result element output (data_o is 0 when no result)
//   yumi_i         : reserved
//   state_o        : current sequencing state (debug)
module systolic_mac_array
  import systolic_mac_array_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               flush_i,
  output logic               ready_o,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic [1:0]         state_o
);

  localparam int w_lp      = array_width_p;
  localparam int h_lp      = array_height_p;
  localparam int slice_lp  = w_lp + h_lp;
  localparam int elems_lp  = w_lp * h_lp;
  localparam int cnt_w_lp  = cnt_width(slice_lp);
  localparam int idx_w_lp  = idx_width(elems_lp);

  typedef logic [cnt_w_lp-1:0] cnt_t;
  typedef logic [idx_w_lp-1:0] idx_t;

  state_e              state_q, state_n;
  cnt_t                cnt_q;    // loader consumer index within a slice
  cnt_t                prop_q;   // cycles spent in PROP
  idx_t                idx_q;    // next result element to register
  logic                pend_q;   // flush requested, not yet drained
  logic                valid_q;
  logic [width_p-1:0]  data_q;
  logic [width_p-1:0]  a_buf_q [h_lp];
  logic [width_p-1:0]  b_buf_q [w_lp];

  logic accept;
  logic slice_done;
  logic drain_start;
  logic prop_done;
  logic drain_done;

  // PE interconnect: a_* flows along rows, b_* flows down columns.
  logic [width_p-1:0] a_in   [h_lp][w_lp];
  logic               a_in_v [h_lp][w_lp];
  logic [width_p-1:0] b_in   [h_lp][w_lp];
  logic               b_in_v [h_lp][w_lp];
  logic [width_p-1:0] a_out  [h_lp][w_lp];
  logic               a_out_v[h_lp][w_lp];
  logic [width_p-1:0] b_out  [h_lp][w_lp];
  logic               b_out_v[h_lp][w_lp];
  logic [width_p-1:0] acc_flat [elems_lp];
  logic [width_p-1:0] drain_sel;
  logic               unused_bits;

  assign accept      = valid_i & ready_o;
  assign slice_done  = accept && (cnt_q == cnt_t'(slice_lp - 1));
  // Drain may only start on a slice boundary so no partial slice is lost.
  assign drain_start = en_i && (state_q == LOAD) && (cnt_q == '0) && pend_q;
  assign prop_done   = en_i && (state_q == PROP) && (prop_q == cnt_t'(slice_lp - 2));
  assign drain_done  = en_i && (state_q == DRAIN) && (idx_q == idx_t'(elems_lp));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LOAD;
    end else if (en_i) begin
      state_q <= state_n;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state_q;
    case (state_q)
      LOAD: begin
        if (drain_start)     state_n = DRAIN;
        else if (slice_done) state_n = PROP;
      end
      PROP: begin
        if (prop_done) state_n = LOAD;
      end
      DRAIN: begin
        if (drain_done) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    // The loader is closed on the cycle a drain starts, so the next slice
    // cannot slip in ahead of the results being read out.
    ready_o = ~reset_i & en_i & (state_q == LOAD) & ~((cnt_q == '0) & pend_q);
    valid_o = ~reset_i & en_i & valid_q;
    data_o  = reset_i ? '0 : data_q;
  end

  assign state_o = state_q;

  // ---------------- loader, flush flag, propagation, drain ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      prop_q  <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int r = 0; r < h_lp; r++) a_buf_q[r] <= '0;
      for (int c = 0; c < w_lp; c++) b_buf_q[c] <= '0;
    end else if (en_i) begin
      if (accept) begin
        cnt_q <= slice_done ? '0 : cnt_q + cnt_t'(1);
      end
      for (int c = 0; c < w_lp; c++) begin
        if (accept && (cnt_q == cnt_t'(c))) b_buf_q[c] <= data_i;
      end
      for (int r = 0; r < h_lp; r++) begin
        if (accept && (cnt_q == cnt_t'(w_lp + r))) a_buf_q[r] <= data_i;
      end

      if (drain_done) begin
        pend_q <= 1'b0;
      end else if (flush_i && (state_q != DRAIN)) begin
        pend_q <= 1'b1;
      end

      if (state_q == PROP) begin
        prop_q <= prop_done ? '0 : prop_q + cnt_t'(1);
      end

      if (drain_start) begin
        valid_q <= 1'b1;
        data_q  <= acc_flat[0];
        idx_q   <= idx_t'(1);
      end else if (state_q == DRAIN) begin
        if (drain_done) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          idx_q   <= '0;
        end else begin
          data_q <= drain_sel;
          idx_q  <= idx_q + idx_t'(1);
        end
      end
    end
  end

  // Row-major result select for the drain.
  always_comb begin
    drain_sel = '0;
    for (int e = 0; e < elems_lp; e++) begin
      if (idx_q == idx_t'(e)) drain_sel = acc_flat[e];
    end
  end

  // ---------------- skewed injection and PE grid ----------------
  // Row r's A enters column 0 on PROP cycle r; column c's B enters row 0 on
  // PROP cycle c. The per-PE register stages then supply the rest of the
  // skew, so a_r and b_c meet in PE(r,c) on PROP cycle r+c.
  always_comb begin
    for (int r = 0; r < h_lp; r++) begin
      for (int c = 0; c < w_lp; c++) begin
        if (c == 0) begin
          a_in[r][c]   = a_buf_q[r];
          a_in_v[r][c] = (state_q == PROP) && (prop_q == cnt_t'(r));
        end else begin
          a_in[r][c]   = a_out[r][c-1];
          a_in_v[r][c] = a_out_v[r][c-1];
        end
        if (r == 0) begin
          b_in[r][c]   = b_buf_q[c];
          b_in_v[r][c] = (state_q == PROP) && (prop_q == cnt_t'(c));
        end else begin
          b_in[r][c]   = b_out[r-1][c];
          b_in_v[r][c] = b_out_v[r-1][c];
        end
      end
    end
  end

  for (genvar r = 0; r < h_lp; r++) begin : g_row
    for (genvar c = 0; c < w_lp; c++) begin : g_col
      systolic_mac_pe #(
        .width_p(width_p)
      ) u_pe (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .clear_i (drain_done),
        .a_i     (a_in[r][c]),
        .a_v_i   (a_in_v[r][c]),
        .b_i     (b_in[r][c]),
        .b_v_i   (b_in_v[r][c]),
        .a_o     (a_out[r][c]),
        .a_v_o   (a_out_v[r][c]),
        .b_o     (b_out[r][c]),
        .b_v_o   (b_out_v[r][c]),
        .acc_o   (acc_flat[r*w_lp + c])
      );
    end
  end

  // Pass-through outputs at the array's right and bottom edges have no
  // consumer; yumi_i is reserved.
  always_comb begin
    unused_bits = yumi_i;
    for (int r = 0; r < h_lp; r++) begin
      unused_bits = unused_bits ^ (^a_out[r][w_lp-1]) ^ a_out_v[r][w_lp-1];
    end
    for (int c = 0; c < w_lp; c++) begin
      unused_bits = unused_bits ^ (^b_out[h_lp-1][c]) ^ b_out_v[h_lp-1][c];
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
module tb_systolic_mac_array;

  localparam int WP = 8;
  localparam int AW = 2;
  localparam int AH = 2;
  localparam int NE = AW * AH;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_i, en_i, flush_i, valid_i, yumi_i;
  logic [WP-1:0] data_i;
  logic          ready_o, valid_o;
  logic [WP-1:0] data_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  systolic_mac_array #(
    .width_p(WP), .array_width_p(AW), .array_height_p(AH)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
    .ready_o(ready_o), .valid_i(valid_i), .data_i(data_i),
    .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o), .state_o(state_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // C accumulates sum over slices of a_r*b_c mod 2^WP; a flush yields C
  // row-major once the slice in progress is complete, then C restarts at 0.
  int            macc [AH][AW];
  int            slice_words[$];
  bit            m_pend;
  logic [WP-1:0] exp_q[$];

  task automatic model_emit();
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) begin
        exp_q.push_back(WP'(macc[r][c]));
        macc[r][c] = 0;
      end
  endtask

  task automatic model_word(input int v);
    slice_words.push_back(v);
    if (slice_words.size() == AW + AH) begin
      for (int r = 0; r < AH; r++)
        for (int c = 0; c < AW; c++)
          macc[r][c] = (macc[r][c] + slice_words[AW + r] * slice_words[c]) % 256;
      slice_words.delete();
      if (m_pend) begin
        model_emit();
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic model_flush();
    if (slice_words.size() == 0) model_emit();
    else m_pend = 1'b1;
  endtask

  int n_valid_seen = 0;
  int burst_left   = 0;

  task automatic model_reset();
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++) macc[r][c] = 0;
    slice_words.delete();
    exp_q.delete();
    m_pend     = 1'b0;
    burst_left = 0;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset_i) begin
      if (!en_i) begin
        check("en_low_ready", ready_o, 0);
        check("en_low_valid", valid_o, 0);
      end else if (valid_o) begin
        n_valid_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("drain_data", data_o, exp_q.pop_front());
        end
        if (burst_left == 0) burst_left = NE - 1;
        else burst_left--;
      end else begin
        if (burst_left != 0) begin
          check("drain_gap", 0, 1);
          burst_left = 0;
        end
        check("idle_data_zero", data_o, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WP-1:0] v, input bit stalls);
    bit ok;
    yumi_i = 1'($urandom_range(0, 1));
    if (stalls && $urandom_range(0, 3) == 0) begin
      en_i = 1'b0; valid_i = 1'b1; data_i = 8'd99;
      repeat ($urandom_range(1, 2)) tick();
      en_i = 1'b1;
    end
    valid_i = 1'b1;
    data_i  = v;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
    else model_word(int'(v));
  endtask

  task automatic send_slice(input int b0, input int b1, input int a0, input int a1);
    send_word(WP'(b0), 1'b0);
    send_word(WP'(b1), 1'b0);
    send_word(WP'(a0), 1'b0);
    send_word(WP'(a1), 1'b0);
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    model_flush();
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (exp_q.size() == 0 && burst_left == 0 && !m_pend) done = 1'b1;
      else tick();
    end
    if (!done) begin
      check("drain_timeout", 0, 1);
      model_reset();
    end
  endtask

  task automatic first_valid_latency(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      lat++;
      if (valid_o) seen = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int base;
    reset_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
    yumi_i = 1'b0; data_i = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ready", ready_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_data", data_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ready_o, 1);
    @(posedge clk); #1;

    // 2x2 product
    send_slice(3, 4, 2, 4);
    send_slice(1, 2, 1, 3);
    check("model_c00", macc[0][0], 7);
    check("model_c01", macc[0][1], 10);
    check("model_c10", macc[1][0], 15);
    check("model_c11", macc[1][1], 22);
    do_flush();
    wait_drain();

    // Immediate second flush: accumulators were cleared
    do_flush();
    check("model_zero_q", exp_q.size(), NE);
    wait_drain();

    // Overflow wrap: 400 mod 256
    send_slice(20, 20, 20, 20);
    check("model_overflow", macc[1][1], 144);
    do_flush();
    wait_drain();

    // en_i low mid-slice with junk on the input
    send_slice(3, 4, 2, 4);
    send_word(8'd1, 1'b0);
    send_word(8'd2, 1'b0);
    en_i = 1'b0; valid_i = 1'b1; data_i = 8'd99;
    repeat (3) tick();
    en_i = 1'b1; valid_i = 1'b0;
    send_word(8'd1, 1'b0);
    send_word(8'd3, 1'b0);
    do_flush();
    wait_drain();

    // Flush after 2 of 4 words: waits for slice + propagation
    send_word(8'd3, 1'b0);
    send_word(8'd4, 1'b0);
    do_flush();
    send_word(8'd2, 1'b0);
    send_word(8'd4, 1'b0);
    check("model_mid_c11", exp_q.size() > 0 ? exp_q[NE-1] : 8'hFF, 16);
    first_valid_latency(lat);
    check("mid_flush_latency", lat, AW + AH + 1);
    wait_drain();

    // Reset after the second drain output
    send_slice(1, 2, 3, 4);
    do_flush();
    base = n_valid_seen;
    for (int n = 0; n < 50 && n_valid_seen < base + 2; n++) tick();
    check("two_outputs_seen", n_valid_seen - base, 2);
    reset_i = 1'b1;
    model_reset();
    @(negedge clk);
    check("reset_mid_drain_valid", valid_o, 0);
    tick();
    reset_i = 1'b0;
    tick();
    do_flush();
    wait_drain();

    // Randomised slices, stalls and flush placement
    for (int it = 0; it < 20; it++) begin
      int nsl;
      int split;
      nsl = $urandom_range(0, 3);
      for (int s = 0; s < nsl; s++)
        for (int w = 0; w < AW + AH; w++) send_word(WP'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        split = $urandom_range(1, AW + AH - 1);
        for (int w = 0; w < split; w++) send_word(WP'($urandom_range(0, 255)), 1'b1);
        do_flush();
        for (int w = split; w < AW + AH; w++) send_word(WP'($urandom_range(0, 255)), 1'b1);
      end else begin
        do_flush();
      end
      wait_drain();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
